// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and seven-segment constants ({g,f,e,d,c,b,a}, active-high).
package stopwatch_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/stopwatch_disp_scan_seg7.sv
// Combinational BCD to seven-segment decoder; codes 0xA-0xF show a dash.
module bcd_to_seg7
    import stopwatch_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    // Map one BCD digit to its segment pattern.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_disp_scan.sv
// Six-digit multiplexed seven-segment scanner with frame-boundary snapshot.
// Optional macro DISP_LZB_EN blanks a leading zero in the hours-tens digit.
module stopwatch_disp_scan
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hr_h,
    input  logic [3:0] hr_l,
    input  logic [3:0] min_h,
    input  logic [3:0] min_l,
    input  logic [3:0] sec_h,
    input  logic [3:0] sec_l,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]      IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    bcd_t             snap_r [NUM_DIGITS];
    logic             wrap_s;
    logic             load_s;
    bcd_t             digit_s;
    logic [6:0]       dec_s;
    logic [6:0]       seg_s;

    assign wrap_s = (cnt_r == CNT_MAX);
    assign load_s = wrap_s && (idx_r == IDX_LAST);

    // Select the snapshot digit currently being scanned.
    always_comb begin
        digit_s = 4'd0;
        case (idx_r)
            3'd0:    digit_s = snap_r[0];
            3'd1:    digit_s = snap_r[1];
            3'd2:    digit_s = snap_r[2];
            3'd3:    digit_s = snap_r[3];
            3'd4:    digit_s = snap_r[4];
            3'd5:    digit_s = snap_r[5];
            default: digit_s = 4'd0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (digit_s),
        .seg (dec_s)
    );

    // Apply optional leading-zero blanking to the hours-tens digit.
    always_comb begin
        seg_s = dec_s;
`ifdef DISP_LZB_EN
        if ((idx_r == 3'd0) && (snap_r[0] == 4'd0)) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = dec_s;
        end
`else
        seg_s = dec_s;
`endif
    end

    // Prescaler, digit index, snapshot and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            idx_r      <= 3'd0;
            snap_r[0]  <= 4'd0;
            snap_r[1]  <= 4'd0;
            snap_r[2]  <= 4'd0;
            snap_r[3]  <= 4'd0;
            snap_r[4]  <= 4'd0;
            snap_r[5]  <= 4'd0;
            an         <= 6'd0;
            seg        <= 7'd0;
            dp         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (wrap_s) begin
                cnt_r <= '0;
                idx_r <= (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            // All six digits are captured together so a rollover never tears.
            if (load_s) begin
                snap_r[0] <= hr_h;
                snap_r[1] <= hr_l;
                snap_r[2] <= min_h;
                snap_r[3] <= min_l;
                snap_r[4] <= sec_h;
                snap_r[5] <= sec_l;
            end
            frame_done <= load_s;
            an         <= 6'b000001 << idx_r;
            seg        <= seg_s;
            dp         <= (idx_r == 3'd1) || (idx_r == 3'd3);
        end
    end

endmodule

// File: tb/tb_stopwatch_disp_scan.sv
// Scoreboard bench: stimulus queues per-edge expectations, a negedge monitor compares them.
module tb_stopwatch_disp_scan;

    localparam int SCAN_DIV = 4;
`ifdef DISP_LZB_EN
    localparam logic [6:0] Z0 = 7'h00;
`else
    localparam logic [6:0] Z0 = 7'h3F;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] hr_h, hr_l, min_h, min_l, sec_h, sec_l;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    typedef struct {
        int         cyc;
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    stopwatch_disp_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .hr_h       (hr_h),
        .hr_l       (hr_l),
        .min_h      (min_h),
        .min_l      (min_l),
        .sec_h      (sec_h),
        .sec_l      (sec_l),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [5:0] a, input logic [6:0] s,
                        input logic d, input logic f, input string tag);
        exp_t e;
        e.cyc = c; e.an = a; e.seg = s; e.dp = d; e.fd = f; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Expected outputs for edges b+1 .. b+n of a frame whose digits decode to s0..s5.
    task automatic push_frame(input int b, input int n,
                              input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5,
                              input string tag);
        logic [6:0] segs [6];
        segs[0] = s0; segs[1] = s1; segs[2] = s2;
        segs[3] = s3; segs[4] = s4; segs[5] = s5;
        for (int k = 1; k <= n; k++) begin
            int         d;
            logic [5:0] a;
            d = (k - 1) / SCAN_DIV;
            a = 6'b000001 << d;
            push(b + k, a, segs[d], (d == 1) || (d == 3), (k == 6 * SCAN_DIV), tag);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every expectation due at this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                n_chk++;
                if (mon_e.cyc != cyc || an !== mon_e.an || seg !== mon_e.seg ||
                    dp !== mon_e.dp || frame_done !== mon_e.fd) begin
                    $display("FAIL %s cyc=%0d: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b (due cyc %0d)",
                             mon_e.tag, cyc, an, seg, dp, frame_done,
                             mon_e.an, mon_e.seg, mon_e.dp, mon_e.fd, mon_e.cyc);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish by time 20000");
        $fatal(1, "watchdog");
    end

    initial begin
        hr_h = 4'd1; hr_l = 4'd2; min_h = 4'd3; min_l = 4'd4; sec_h = 4'd5; sec_l = 4'd9;

        push(3, 6'd0, 7'd0, 1'b0, 1'b0, "reset");
        push_frame(3,   24, Z0,    7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, "frame1_zero");
        push_frame(27,  24, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h6F, "frame2_digits");
        push_frame(51,  24, 7'h06, 7'h40, 7'h4F, 7'h66, 7'h6D, 7'h4F, "frame3_antitear");
        push_frame(75,  24, 7'h06, 7'h40, 7'h4F, 7'h66, 7'h6D, 7'h66, "frame4_newsec");
        push_frame(99,  13, 7'h06, 7'h40, 7'h4F, 7'h66, 7'h6D, 7'h66, "frame5_partial");
        push(113, 6'd0, 7'd0, 1'b0, 1'b0, "midreset");
        push(114, 6'd0, 7'd0, 1'b0, 1'b0, "midreset_hold");
        push_frame(114, 24, Z0,    7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, "post_reset_zero");
        push_frame(138, 24, 7'h06, 7'h40, 7'h4F, 7'h66, 7'h6D, 7'h66, "post_reset_data");
        push_frame(162, 24, Z0,    7'h40, 7'h4F, 7'h66, 7'h6D, 7'h66, "lzb_hr_h_zero");

        wait_cyc(3);
        rst = 1'b0;
        // Changed mid-frame 2; only the load at cycle 51 may pick these up.
        wait_cyc(40);
        sec_l = 4'd3;
        hr_l  = 4'hC;
        // sec_l changes while digit 2 is being scanned in frame 3.
        wait_cyc(61);
        sec_l = 4'd4;
        wait_cyc(112);
        rst = 1'b1;
        wait_cyc(114);
        rst = 1'b0;
        wait_cyc(150);
        hr_h = 4'd0;
        wait_cyc(187);

        n_chk++;
        if (exp_q.size() != 0) begin
            $display("FAIL leftover: %0d expectations never checked, want 0", exp_q.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
